// File: rtl/display_mux_controller_pkg.sv
// Shared types and helpers for the multiplexed seven-segment display controller.
package display_pkg;

  localparam int SEG_BLANK_NIBBLE_W = 4;

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} slot_state_e;

  // Value an anode pin takes when its digit is lit.
  function automatic logic anode_on(input logic active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/display_mux_controller_seven_segment.sv
// Hex nibble to seven-segment decoder, segments {g,f,e,d,c,b,a}, active-low
// (0 = segment lit) for common-anode digits.
module seven_segment
  import display_pkg::*;
(
  input  logic [SEG_BLANK_NIBBLE_W-1:0] nibble,
  output logic [6:0]                    seg
);

  always_comb begin
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_mux_controller.sv
// Time-multiplexed refresh controller: one shared decoder, per-digit slots with a
// leading blank interval, and digit values double-buffered to frame boundaries.
module display_mux_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS       = 2,
  parameter int REFRESH_CYCLES   = 24000,
  parameter int BLANK_CYCLES     = 100,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         mask_in,
  output logic                          load_ack,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [6:0]                    seg
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_DIGITS - 1);
  localparam logic AN_ON  = anode_on(ANODE_ACTIVE_LOW != 0);
  localparam logic AN_OFF = ~AN_ON;

  if (NUM_DIGITS < 2 || REFRESH_CYCLES < 2 || BLANK_CYCLES < 1 ||
      BLANK_CYCLES >= REFRESH_CYCLES || ANODE_ACTIVE_LOW < 0 || ANODE_ACTIVE_LOW > 1)
  begin : g_bad_params
    $error("display_mux_controller: invalid parameter combination");
  end

  logic [CNT_W-1:0]              slot_cnt, slot_cnt_next;
  logic [SEL_W-1:0]              sel_next;
  logic [4*NUM_DIGITS-1:0]       active_digits, active_digits_next, pending_digits;
  logic [NUM_DIGITS-1:0]         active_mask, active_mask_next, pending_mask, anode_next;
  logic                          pending_valid, slot_end, boundary, commit;
  logic [SEG_BLANK_NIBBLE_W-1:0] nibble;
  slot_state_e                   state_next;

  // Next counter/selection/active values; anode is precomputed from them so the
  // registered anode lines up with the slot_cnt of the same cycle.
  always_comb begin
    slot_end           = (slot_cnt == LAST_CNT);
    boundary           = slot_end && (digit_sel == LAST_SEL);
    commit             = boundary && (load || pending_valid);
    slot_cnt_next      = slot_end ? '0 : slot_cnt + 1'b1;
    sel_next           = digit_sel;
    active_digits_next = active_digits;
    active_mask_next   = active_mask;
    if (slot_end) begin
      sel_next = (digit_sel == LAST_SEL) ? '0 : digit_sel + 1'b1;
    end else begin
      sel_next = digit_sel;
    end
    if (boundary && load) begin
      active_digits_next = digits_in;
      active_mask_next   = mask_in;
    end else if (boundary && pending_valid) begin
      active_digits_next = pending_digits;
      active_mask_next   = pending_mask;
    end else begin
      active_digits_next = active_digits;
      active_mask_next   = active_mask;
    end
    state_next = (slot_cnt_next < BLANK_END) ? BLANK : DRIVE;
    anode_next = {NUM_DIGITS{AN_OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anode_next[i] = (state_next == DRIVE && sel_next == SEL_W'(i) && !active_mask_next[i])
                      ? AN_ON : AN_OFF;
    end
  end

  // Slot timing, double buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt       <= '0;
      digit_sel      <= '0;
      active_digits  <= '0;
      active_mask    <= '0;
      pending_digits <= '0;
      pending_mask   <= '0;
      pending_valid  <= 1'b0;
      load_ack       <= 1'b0;
      anode          <= {NUM_DIGITS{AN_OFF}};
    end else begin
      slot_cnt      <= slot_cnt_next;
      digit_sel     <= sel_next;
      active_digits <= active_digits_next;
      active_mask   <= active_mask_next;
      load_ack      <= commit;
      anode         <= anode_next;
      if (boundary) begin
        pending_valid <= 1'b0;
      end else if (load) begin
        pending_digits <= digits_in;
        pending_mask   <= mask_in;
        pending_valid  <= 1'b1;
      end else begin
        pending_valid <= pending_valid;
      end
    end
  end

  // Nibble of the digit currently being scanned.
  always_comb begin
    nibble = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nibble = (digit_sel == SEL_W'(i)) ? active_digits[4*i +: 4] : nibble;
    end
  end

  seven_segment u_dec (
    .nibble (nibble),
    .seg    (seg)
  );

endmodule

// File: tb/tb_display_mux_controller.sv
// Bench for display_mux_controller: directed table, hand-written corner sequences
// and randomized traffic against a frame-arithmetic reference model.
module tb_display_mux_controller;

  localparam int N = 2;
  localparam int R = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] digits_in = 8'h00;
  logic [1:0] mask_in = 2'b00;
  logic       load_ack, load_ack_b;
  logic       digit_sel, digit_sel_b;
  logic [1:0] anode, anode_b;
  logic [6:0] seg, seg_b;

  int n_vec = 0;
  int n_err = 0;

  display_mux_controller #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B),
                           .ANODE_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .mask_in(mask_in),
    .load_ack(load_ack), .digit_sel(digit_sel), .anode(anode), .seg(seg));

  display_mux_controller #(.NUM_DIGITS(N), .REFRESH_CYCLES(R), .BLANK_CYCLES(B),
                           .ANODE_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .mask_in(mask_in),
    .load_ack(load_ack_b), .digit_sel(digit_sel_b), .anode(anode_b), .seg(seg_b));

  always #5 clk = ~clk;

  // Lit segments {g,f,e,d,c,b,a} for each hex digit; the display drives them low.
  logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] dec(input logic [3:0] n);
    return ~lit[n];
  endfunction

  function automatic logic [1:0] inv2(input logic [1:0] v);
    return ~v;
  endfunction

  // Reference model: cycle index since reset plus the two buffers.
  int         t = 0;
  bit         mv = 1'b0;
  logic [7:0] act_d = 8'h00, pend_d = 8'h00;
  logic [1:0] act_m = 2'b00, pend_m = 2'b00;
  bit         pend_v = 1'b0, exp_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit ld, input logic [7:0] d,
                            input logic [1:0] m);
    if (rst) begin
      t = 0; act_d = 8'h00; act_m = 2'b00; pend_v = 1'b0; exp_ack = 1'b0;
    end else begin
      if (t % (R * N) == R * N - 1) begin
        exp_ack = ld || pend_v;
        if (ld) begin act_d = d; act_m = m; end
        else if (pend_v) begin act_d = pend_d; act_m = pend_m; end
        pend_v = 1'b0;
      end else begin
        exp_ack = 1'b0;
        if (ld) begin pend_d = d; pend_m = m; pend_v = 1'b1; end
      end
      t++;
    end
  endtask

  task automatic check_model();
    int pos, sel;
    logic [1:0] hi;
    logic [3:0] nib;
    pos = t % R;
    sel = (t / R) % N;
    hi  = (pos < B || act_m[sel]) ? 2'b00 : 2'(1 << sel);
    nib = act_d[sel*4 +: 4];
    chk("anode", {30'd0, anode}, {30'd0, inv2(hi)});
    chk("anode_pos", {30'd0, anode_b}, {30'd0, hi});
    chk("digit_sel", {31'd0, digit_sel}, sel);
    chk("load_ack", {31'd0, load_ack}, {31'd0, exp_ack});
    chk("load_ack_pos", {31'd0, load_ack_b}, {31'd0, exp_ack});
    chk("seg", {25'd0, seg}, {25'd0, dec(nib)});
  endtask

  // One clock: check the current cycle, drive the inputs for it, take the edge.
  task automatic tick(input bit rst, input bit ld, input logic [7:0] d, input logic [1:0] m);
    if (mv) check_model();
    reset = rst; load = ld; digits_in = d; mask_in = m;
    @(posedge clk);
    model_edge(rst, ld, d, m);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 8'h00, 2'b00);
      mv = 1'b1;
    end
  endtask

  typedef struct {
    int         cyc;
    logic [1:0] an;
    logic       sel;
    logic       ack;
    logic [3:0] nib;
  } row_t;

  row_t tbl[14];

  initial begin
    int acks;
    // Expected outputs for reset then load of 8'h35 at cycle 11.
    tbl[0]  = '{0,  2'b11, 1'b0, 1'b0, 4'h0};
    tbl[1]  = '{1,  2'b11, 1'b0, 1'b0, 4'h0};
    tbl[2]  = '{2,  2'b10, 1'b0, 1'b0, 4'h0};
    tbl[3]  = '{7,  2'b10, 1'b0, 1'b0, 4'h0};
    tbl[4]  = '{8,  2'b11, 1'b1, 1'b0, 4'h0};
    tbl[5]  = '{9,  2'b11, 1'b1, 1'b0, 4'h0};
    tbl[6]  = '{10, 2'b01, 1'b1, 1'b0, 4'h0};
    tbl[7]  = '{15, 2'b01, 1'b1, 1'b0, 4'h0};
    tbl[8]  = '{16, 2'b11, 1'b0, 1'b1, 4'h5};
    tbl[9]  = '{17, 2'b11, 1'b0, 1'b0, 4'h5};
    tbl[10] = '{18, 2'b10, 1'b0, 1'b0, 4'h5};
    tbl[11] = '{24, 2'b11, 1'b1, 1'b0, 4'h3};
    tbl[12] = '{31, 2'b01, 1'b1, 1'b0, 4'h3};
    tbl[13] = '{32, 2'b11, 1'b0, 1'b0, 4'h5};

    do_reset();
    for (int c = 0; c < 34; c++) begin
      for (int k = 0; k < 14; k++) begin
        if (tbl[k].cyc == c) begin
          chk("tbl_anode", {30'd0, anode}, {30'd0, tbl[k].an});
          chk("tbl_sel", {31'd0, digit_sel}, {31'd0, tbl[k].sel});
          chk("tbl_ack", {31'd0, load_ack}, {31'd0, tbl[k].ack});
          chk("tbl_seg", {25'd0, seg}, {25'd0, dec(tbl[k].nib)});
        end
      end
      tick(1'b0, c == 11, 8'h35, 2'b00);
    end
    // Four frames of the bare scan pattern.
    do_reset();
    for (int c = 0; c < 64; c++) tick(1'b0, 1'b0, 8'h00, 2'b00);

    // Two loads in one frame: last write wins, single ack.
    do_reset();
    acks = 0;
    for (int c = 0; c < 34; c++) begin
      if (load_ack) acks++;
      if (c == 16) chk("lww_seg0", {25'd0, seg}, {25'd0, dec(4'h9)});
      if (c == 24) chk("lww_seg1", {25'd0, seg}, {25'd0, dec(4'h7)});
      tick(1'b0, c == 3 || c == 12, (c == 3) ? 8'h12 : 8'h79, 2'b00);
    end
    chk("lww_ack_count", acks, 1);

    // Load on the boundary edge itself.
    do_reset();
    for (int c = 0; c < 34; c++) begin
      if (c == 16) begin
        chk("bnd_ack", {31'd0, load_ack}, 1);
        chk("bnd_seg", {25'd0, seg}, {25'd0, dec(4'hA)});
      end
      if (c == 32) chk("bnd_no_reack", {31'd0, load_ack}, 0);
      tick(1'b0, c == 15, 8'h4A, 2'b00);
    end

    // Masked digit 1.
    do_reset();
    for (int c = 0; c < 34; c++) begin
      if (c == 20) chk("mask_d0", {30'd0, anode}, {30'd0, 2'b10});
      if (c == 27) begin
        chk("mask_d1", {30'd0, anode}, {30'd0, 2'b11});
        chk("mask_d1_pos", {30'd0, anode_b}, {30'd0, 2'b00});
      end
      tick(1'b0, c == 5, 8'h35, 2'b10);
    end

    // Reset with a pending load, colliding with a fresh load.
    do_reset();
    for (int c = 0; c < 13; c++) tick(1'b0, c == 3, 8'h35, 2'b00);
    tick(1'b1, 1'b1, 8'h35, 2'b00);
    chk("rst_anode", {30'd0, anode}, {30'd0, 2'b11});
    chk("rst_sel", {31'd0, digit_sel}, 0);
    for (int c = 0; c < 18; c++) begin
      if (c == 16) begin
        chk("rst_no_ack", {31'd0, load_ack}, 0);
        chk("rst_seg", {25'd0, seg}, {25'd0, dec(4'h0)});
      end
      tick(1'b0, 1'b0, 8'h00, 2'b00);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
           8'($urandom), 2'($urandom));
    end
    tick(1'b0, 1'b0, 8'h00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
